iq_mixer: RTL and testbench

Parametrised quadrature mixer for the SDR receive chain. It sits between the ADC capture register and the CIC decimators. It converts raw ADC samples to two's complement and removes the DC offset with a leaky-integrator tracker. It multiplies the corrected sample by the NCO sine and cosine, then applies a programmable gain shift and round/saturate to produce I/Q samples with a valid strobe.

---
 rtl/iq_mixer.sv | 148 ++++++++++++++
 tb/tb_iq_mixer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/iq_mixer.sv
// Quadrature mixer: ADC sample -> DC removal -> x sin/cos -> gain, round, sat.
// Four register stages, one sample per clock, valid strobe follows the data.
module iq_mixer #(
  parameter int ADC_W         = 8,
  parameter int NCO_W         = 10,
  parameter int COEF_W        = 8,
  parameter int OUT_W         = 16,
  parameter int DC_SHIFT      = 10,
  parameter int OFFSET_BINARY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADC_W-1:0]         adc_data,
  input  logic                     adc_valid,
  input  logic [NCO_W-1:0]         fsin,
  input  logic [NCO_W-1:0]         fcos,
  input  logic                     dc_en,
  input  logic [3:0]               gain,
  output logic signed [OUT_W-1:0]  sin_o,
  output logic signed [OUT_W-1:0]  cos_o,
  output logic                     out_valid,
  output logic signed [ADC_W:0]    dc_est
);

  localparam int PW = ADC_W + 1 + COEF_W;
  localparam int VW = PW + 16;
  localparam int AW = ADC_W + DC_SHIFT + 1;
  localparam int R  = (PW > OUT_W) ? PW - OUT_W : 0;

  localparam logic [VW-1:0] ONE = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] RND = (ONE << R) >> 1;
  localparam logic signed [VW-1:0] MAXV =
    {{(VW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [VW-1:0] MINV =
    {{(VW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // S1 state
  logic                     v1, en1;
  logic signed [ADC_W-1:0]  d1;
  logic signed [COEF_W-1:0] s1, c1;

  // S2 state
  logic                     v2;
  logic signed [ADC_W:0]    x2;
  logic signed [COEF_W-1:0] s2, c2;
  logic signed [AW-1:0]     acc;

  // S3 state
  logic                     v3;
  logic signed [PW-1:0]     pq, pi;

  // Offset binary to two's complement is a flip of the MSB
  logic [ADC_W-1:0] d1_n;
  assign d1_n = adc_data
    ^ {(OFFSET_BINARY != 0), {(ADC_W-1){1'b0}}};

  logic signed [AW-1:0] acc_sh;
  assign acc_sh = acc >>> DC_SHIFT;
  assign dc_est = acc_sh[ADC_W:0];

  logic signed [ADC_W:0] d1x, diff;
  assign d1x  = {d1[ADC_W-1], d1};
  assign diff = d1x - dc_est;

  logic signed [AW-1:0] diff_x;
  assign diff_x = {{DC_SHIFT{diff[ADC_W]}}, diff};

  function automatic logic signed [OUT_W-1:0] scale(
    input logic signed [PW-1:0] p,
    input logic [3:0]           g
  );
    logic signed [VW-1:0] v;
    v = VW'(p) <<< g;
    v = (v + $signed(RND)) >>> R;
    if (v > MAXV)
      v = MAXV;
    else if (v < MINV)
      v = MINV;
    return v[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      en1 <= 1'b0;
      d1 <= '0;
      s1 <= '0;
      c1 <= '0;
    end else begin
      v1 <= adc_valid;
      if (adc_valid) begin
        en1 <= dc_en;
        d1  <= d1_n;
        s1  <= fsin[NCO_W-1 -: COEF_W];
        c1  <= fcos[NCO_W-1 -: COEF_W];
      end
    end
  end

  // Subtraction uses the estimate from before this edge's update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2 <= 1'b0;
      x2 <= '0;
      s2 <= '0;
      c2 <= '0;
      acc <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        x2 <= en1 ? diff : d1x;
        s2 <= s1;
        c2 <= c1;
        if (en1)
          acc <= acc + diff_x;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3 <= 1'b0;
      pq <= '0;
      pi <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        pq <= x2 * s2;
        pi <= x2 * c2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sin_o <= '0;
      cos_o <= '0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        sin_o <= scale(pq, gain);
        cos_o <= scale(pi, gain);
      end
    end
  end

endmodule

// File: tb/tb_iq_mixer.sv
// Directed bench for iq_mixer: reset/flush, products, rounding,
// saturation, bubbles and DC tracking (DC_SHIFT=4).
module tb_iq_mixer;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        adc_data;
  logic              adc_valid;
  logic [9:0]        fsin, fcos;
  logic              dc_en;
  logic [3:0]        gain;
  logic signed [15:0] sin_o, cos_o;
  logic              out_valid;
  logic signed [8:0] dc_est;

  int total = 0;
  int bad = 0;

  iq_mixer #(
    .ADC_W(8), .NCO_W(10), .COEF_W(8), .OUT_W(16),
    .DC_SHIFT(4), .OFFSET_BINARY(1)
  ) dut (
    .clk(clk), .reset(reset),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .fsin(fsin), .fcos(fcos),
    .dc_en(dc_en), .gain(gain),
    .sin_o(sin_o), .cos_o(cos_o),
    .out_valid(out_valid), .dc_est(dc_est)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One sample, then idle until it has reached the output register
  task automatic push(
    input logic [7:0] d,
    input logic [9:0] s,
    input logic [9:0] c
  );
    adc_data = d;
    fsin = s;
    fcos = c;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (3) tick();
  endtask

  int bexp[4] = '{64, 127, 191, 254};
  int hold_v;
  int ev;

  initial begin
    reset = 1'b1;
    adc_valid = 1'b1;
    adc_data = 8'h80;
    fsin = 10'h3FC;
    fcos = 10'h1FC;
    dc_en = 1'b0;
    gain = 4'd0;
    repeat (3) tick();
    chk("rst_ov", $signed({1'b0, out_valid}), 0);
    chk("rst_sin", sin_o, 0);
    chk("rst_cos", cos_o, 0);
    chk("rst_dc", dc_est, 0);

    reset = 1'b0;
    tick();
    adc_valid = 1'b0;
    chk("flush1_ov", $signed({1'b0, out_valid}), 0);
    tick();
    chk("flush2_ov", $signed({1'b0, out_valid}), 0);
    tick();
    chk("flush3_ov", $signed({1'b0, out_valid}), 0);
    tick();
    chk("lat_ov", $signed({1'b0, out_valid}), 1);
    chk("mid_sin", sin_o, 0);
    chk("mid_cos", cos_o, 0);
    tick();
    chk("pulse_ov", $signed({1'b0, out_valid}), 0);

    push(8'hFF, 10'h1FC, 10'h200);
    chk("fs_ov", $signed({1'b0, out_valid}), 1);
    chk("fs_sin", sin_o, 8065);
    chk("fs_cos", cos_o, -8128);

    gain = 4'd1;
    push(8'hFF, 10'h1FC, 10'h200);
    chk("g1_sin", sin_o, 16129);
    chk("g1_cos", cos_o, -16256);

    gain = 4'd4;
    push(8'hFF, 10'h1FC, 10'h200);
    chk("sat_sin", sin_o, 32767);
    chk("sat_cos", cos_o, -32768);
    tick();
    chk("hold_ov", $signed({1'b0, out_valid}), 0);
    chk("hold_sin", sin_o, 32767);
    chk("hold_cos", cos_o, -32768);

    gain = 4'd0;
    push(8'h00, 10'h1FC, 10'h200);
    chk("neg_sin", sin_o, -8128);
    chk("neg_cos", cos_o, 8192);

    gain = 4'd2;
    push(8'h00, 10'h1FC, 10'h200);
    chk("edge_sin", sin_o, -32512);
    chk("edge_cos", cos_o, 32767);

    gain = 4'd0;
    push(8'h7F, 10'h1FC, 10'h1FC);
    chk("rnd_sin", sin_o, -63);
    chk("rnd_cos", cos_o, -63);

    hold_v = -63;
    fsin = 10'h1FC;
    fcos = 10'h1FC;
    for (int i = 0; i < 12; i++) begin
      if (i < 8 && i % 2 == 0) begin
        adc_valid = 1'b1;
        adc_data = 8'h81 + 8'(i / 2);
      end else begin
        adc_valid = 1'b0;
      end
      tick();
      ev = (i >= 3 && i - 3 < 8 && (i - 3) % 2 == 0) ? 1 : 0;
      if (ev == 1)
        hold_v = bexp[(i - 3) / 2];
      chk($sformatf("bub%0d_ov", i),
          $signed({1'b0, out_valid}), ev);
      chk($sformatf("bub%0d_sin", i), sin_o, hold_v);
      chk($sformatf("bub%0d_cos", i), cos_o, hold_v);
    end

    dc_en = 1'b1;
    adc_data = 8'h90;
    adc_valid = 1'b1;
    tick();
    tick();
    chk("dc_first_est", dc_est, 1);
    tick();
    tick();
    chk("dc_first_cos", cos_o, 1016);
    repeat (400) tick();
    chk("dc_conv_est", dc_est, 16);
    chk("dc_conv_cos", cos_o, 0);
    chk("dc_conv_sin", sin_o, 0);
    repeat (20) tick();
    chk("dc_stable_est", dc_est, 16);
    chk("dc_stable_ov", $signed({1'b0, out_valid}), 1);
    chk("dc_stable_cos", cos_o, 0);
    adc_valid = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
